shift_add_multiplier: RTL and testbench

//   Sequential unsigned shift-and-add multiplier, the multiply counterpart of the

---
 rtl/shift_add_multiplier_if.sv | 21 ++
 rtl/shift_add_multiplier.sv | 68 ++++++
 tb/tb_shift_add_multiplier.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/operand request and busy/done/product response bundle
interface shift_add_multiplier_if #(
    parameter int N = 10
);
    logic           start;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (
        output start, A, B,
        input  busy, done, product
    );

    modport slave (
        input  start, A, B,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned shift-and-add multiplier, one add-or-skip step per cycle
module shift_add_multiplier #(
    parameter int N = 10
) (
    input logic                 clk,
    input logic                 rst,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state, state_n;
    logic [N-1:0]   m;
    logic [N:0]     acc;
    logic [N-1:0]   q;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] product;
    logic [N:0]     sum;
    logic           last;

    // acc[N] is always zero between steps, so adding the full register equals adding its low N bits
    always_comb begin
        sum  = acc + (q[0] ? {1'b0, m} : '0);
        last = cnt == CW'(N - 1);
    end

    // Next-state and Moore output decode
    always_comb begin
        state_n = state == IDLE ? (bus.start ? CALC : IDLE) :
                  state == CALC ? (last ? DONE : CALC) : IDLE;
        bus.busy    = state != IDLE;
        bus.done    = state == DONE;
        bus.product = product;
    end

    // State register; reset aborts any operation in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Datapath: capture operands, shift {acc,q} right after each conditional add, publish on DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                m   <= bus.A;
                q   <= bus.B;
                acc <= '0;
                cnt <= '0;
            end
        end else if (state == CALC) begin
            acc <= {1'b0, sum[N:1]};
            q   <= {sum[0], q[N-1:1]};
            cnt <= cnt + 1'b1;
        end else if (state == DONE) begin
            product <= {acc[N-1:0], q};
        end
    end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: table-driven and randomized checks of the shift-add multiplier
module tb_shift_add_multiplier;
    localparam int N = 10;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
        bit             interfere;
        string          name;
    } vec_t;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    logic [2*N-1:0] last_prod = '0;

    shift_add_multiplier_if #(.N(N)) ifc ();

    shift_add_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] want, input bit interfere, input string name);
        int  n;
        bit  busy_ok;
        ifc.A = a;
        ifc.B = b;
        ifc.start = 1;
        chk({name, " idle_before"}, ifc.busy, 0);
        tick();
        ifc.start = 0;
        ifc.A = N'($urandom);
        ifc.B = N'($urandom);
        chk({name, " busy_after_accept"}, ifc.busy, 1);
        n = 0;
        busy_ok = 1;
        while (!ifc.done && n < 40) begin
            if (interfere) begin
                ifc.start = n < 5;
                ifc.A = 1;
                ifc.B = 1;
            end
            tick();
            n++;
            if (!ifc.busy) busy_ok = 0;
        end
        ifc.start = 0;
        chk({name, " latency"}, n, N);
        chk({name, " done"}, ifc.done, 1);
        if (interfere) chk({name, " busy_held"}, busy_ok, 1);
        chk({name, " prior_product_held"}, ifc.product, last_prod);
        tick();
        chk({name, " done_pulse"}, ifc.done, 0);
        chk({name, " busy_cleared"}, ifc.busy, 0);
        chk({name, " product"}, ifc.product, want);
        last_prod = want;
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{a: 3,    b: 5,    p: 15,      interfere: 0, name: "t1_3x5"};
        tbl[1] = '{a: 1023, b: 1023, p: 1046529, interfere: 0, name: "t2_max"};
        tbl[2] = '{a: 0,    b: 777,  p: 0,       interfere: 0, name: "t3_zero_a"};
        tbl[3] = '{a: 777,  b: 0,    p: 0,       interfere: 0, name: "t3_zero_b"};
        tbl[4] = '{a: 12,   b: 34,   p: 408,     interfere: 1, name: "t4_ignore"};
        tbl[5] = '{a: 100,  b: 200,  p: 20000,   interfere: 0, name: "t5_b2b"};

        ifc.start = 0;
        ifc.A = 0;
        ifc.B = 0;
        #3;
        chk("reset_busy", ifc.busy, 0);
        chk("reset_done", ifc.done, 0);
        chk("reset_product", ifc.product, 0);
        #4 rst = 0;
        tick();
        repeat (3) tick();
        chk("idle_hold_busy", ifc.busy, 0);
        chk("idle_hold_product", ifc.product, 0);

        for (int i = 0; i < 6; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].interfere, tbl[i].name);

        ifc.A = 50;
        ifc.B = 60;
        ifc.start = 1;
        tick();
        ifc.start = 0;
        repeat (4) tick();
        #2 rst = 1;
        #1;
        chk("t6_rst_busy", ifc.busy, 0);
        chk("t6_rst_done", ifc.done, 0);
        chk("t6_rst_product", ifc.product, 0);
        #2 rst = 0;
        last_prod = '0;
        tick();
        chk("t6_post_rst_idle", ifc.busy, 0);
        do_op(7, 9, 63, 0, "t6_after_rst");

        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] a, b;
            longint       ref_p;
            a = N'($urandom);
            b = N'($urandom);
            if (i == 0) a = '1;
            if (i == 1) b = 1;
            ref_p = longint'(a) * longint'(b);
            do_op(a, b, (2*N)'(ref_p), i % 7 == 3, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
